// File: rtl/count_pkg.sv
// count_pkg: shared types and constants for the push-button counter front end.
//   state_t  - controller FSM encoding (IDLE / DELAY / REPEAT / LOCK)
//   UP, DOWN - values driven on UP_DOWN towards the up/down modulo counter
//   max2()   - elaboration-time helper for sizing the repeat timer
package count_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2,
        LOCK   = 2'd3
    } state_t;

    localparam logic UP   = 1'b1;
    localparam logic DOWN = 1'b0;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchroniser followed by a counting debouncer for one
// raw push-button.
//   CLK  - system clock, rising edge
//   RSTn - synchronous active-low reset
//   BTN  - raw, asynchronous, bouncy button level (active-high)
//   DEB  - debounced level; changes only after DEB_CYCLES consecutive
//          synchronised samples that differ from the current DEB
module btn_debounce #(
    parameter int DEB_CYCLES = 1000
) (
    input  logic CLK,
    input  logic RSTn,
    input  logic BTN,
    output logic DEB
);

    localparam int              CW       = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;

    // NOTE: every register here is updated with <= so all flops sample the
    // values from before the edge; a blocking '=' would let s2 see this
    // cycle's s1 and collapse the synchroniser into a single stage.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            DEB <= 1'b0;
            cnt <= '0;
        end else begin
            s1 <= BTN;
            s2 <= s1;
            // Any sample that agrees with the accepted level restarts the
            // stability count, so a bounce back aborts a pending change.
            if (s2 == DEB) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                DEB <= s2;
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/count_ctrl.sv
// count_ctrl: turns two raw push-buttons into ENABLE/UP_DOWN commands for the
// up/down modulo counter. One pulse per press, auto-repeat while held, and no
// pulses at all while both buttons are down.
//   CLK      - system clock, rising edge
//   RSTn     - synchronous active-low reset
//   BTN_UP   - raw up button (active-high, bouncy)
//   BTN_DOWN - raw down button (active-high, bouncy)
//   ENABLE   - registered one-cycle count-enable pulse
//   UP_DOWN  - registered direction (1 = up, 0 = down), changes only with a pulse
module count_ctrl
    import count_pkg::*;
#(
    parameter int DEB_CYCLES = 1000,
    parameter int REP_DELAY  = 50000,
    parameter int REP_PERIOD = 10000
) (
    input  logic CLK,
    input  logic RSTn,
    input  logic BTN_UP,
    input  logic BTN_DOWN,
    output logic ENABLE,
    output logic UP_DOWN
);

    localparam int            TW         = $clog2(max2(REP_DELAY, REP_PERIOD));
    localparam logic [TW-1:0] DELAY_LAST = TW'(REP_DELAY - 1);
    localparam logic [TW-1:0] PERIOD_LAST = TW'(REP_PERIOD - 1);

    logic          deb_up;
    logic          deb_down;
    state_t        state;
    state_t        state_d;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_d;
    logic          pulse;
    logic          dir_d;

    logic both_held;
    logic any_held;
    logic active_held;
    logic expired;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
        .CLK  (CLK),
        .RSTn (RSTn),
        .BTN  (BTN_UP),
        .DEB  (deb_up)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_down (
        .CLK  (CLK),
        .RSTn (RSTn),
        .BTN  (BTN_DOWN),
        .DEB  (deb_down)
    );

    // UP_DOWN still holds the direction of the press being serviced, so it
    // tells us which debounced level must stay high to keep repeating.
    assign both_held   = deb_up & deb_down;
    assign any_held    = deb_up | deb_down;
    assign active_held = (UP_DOWN == UP) ? deb_up : deb_down;
    assign expired     = (state == DELAY) ? (timer == DELAY_LAST) : (timer == PERIOD_LAST);

    // State register, timer and registered outputs.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state   <= IDLE;
            timer   <= '0;
            ENABLE  <= 1'b0;
            UP_DOWN <= UP;
        end else begin
            state   <= state_d;
            timer   <= timer_d;
            ENABLE  <= pulse;
            UP_DOWN <= dir_d;
        end
    end

    // Next-state logic. The both-held and release checks come before timer
    // expiry, so a release or conflict on the expiry edge suppresses the pulse.
    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: begin
                if (both_held)     state_d = LOCK;
                else if (any_held) state_d = DELAY;
            end
            DELAY: begin
                if (both_held)         state_d = LOCK;
                else if (!active_held) state_d = IDLE;
                else if (expired)      state_d = REPEAT;
            end
            REPEAT: begin
                if (both_held)         state_d = LOCK;
                else if (!active_held) state_d = IDLE;
            end
            LOCK: begin
                if (!any_held) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output / timer logic.
    // NOTE: every signal is given a default before the case so no path leaves
    // it unassigned; otherwise synthesis would infer a latch to hold it.
    always_comb begin
        pulse   = 1'b0;
        dir_d   = UP_DOWN;
        timer_d = timer;
        unique case (state)
            IDLE: begin
                if (any_held && !both_held) begin
                    pulse   = 1'b1;
                    dir_d   = deb_up ? UP : DOWN;
                    timer_d = '0;
                end
            end
            DELAY, REPEAT: begin
                if (!both_held && active_held) begin
                    if (expired) begin
                        pulse   = 1'b1;
                        timer_d = '0;
                    end else begin
                        timer_d = timer + TW'(1);
                    end
                end
            end
            default: begin
                pulse   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_count_ctrl.sv
// tb_count_ctrl: directed scenarios for count_ctrl with DEB_CYCLES=4,
// REP_DELAY=8, REP_PERIOD=3. Each scenario pushes its hand-computed pulses
// (cycle number, direction) into a queue; a monitor pops and compares them
// whenever ENABLE is seen high. Cycle numbers count rising edges; inputs are
// driven and outputs sampled on the falling edge.
module tb_count_ctrl;
    import count_pkg::*;

    localparam int DEB = 4;
    localparam int RD  = 8;
    localparam int RP  = 3;

    logic CLK      = 1'b0;
    logic RSTn     = 1'b0;
    logic BTN_UP   = 1'b0;
    logic BTN_DOWN = 1'b0;
    logic ENABLE;
    logic UP_DOWN;

    count_ctrl #(
        .DEB_CYCLES (DEB),
        .REP_DELAY  (RD),
        .REP_PERIOD (RP)
    ) dut (
        .CLK      (CLK),
        .RSTn     (RSTn),
        .BTN_UP   (BTN_UP),
        .BTN_DOWN (BTN_DOWN),
        .ENABLE   (ENABLE),
        .UP_DOWN  (UP_DOWN)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Set when the most recent rising edge applied reset.
    logic rst_seen = 1'b1;
    always @(posedge CLK) rst_seen <= !RSTn;

    typedef struct {
        int   at;
        logic dir;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   done   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic push(input int at, input logic dir);
        exp_t e;
        e.at  = at;
        e.dir = dir;
        sb.push_back(e);
    endtask

    // Monitor / scoreboard.
    logic prev_en  = 1'b0;
    logic prev_dir = 1'b1;
    always @(negedge CLK) begin
        exp_t e;
        if (!done) begin
            while (sb.size() > 0 && sb[0].at < cyc) begin
                e = sb.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_pulse: expected ENABLE at cycle %0d, still absent at cycle %0d", e.at, cyc);
            end
            if (ENABLE === 1'b1) begin
                check("enable_not_back_to_back", prev_en, 0);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: ENABLE high at cycle %0d, no pulse expected", cyc);
                end else begin
                    e = sb.pop_front();
                    check("pulse_cycle", cyc, e.at);
                    check("pulse_dir", UP_DOWN, e.dir);
                end
            end
            if (UP_DOWN !== prev_dir)
                check("up_down_changes_only_with_pulse_or_reset", ENABLE | rst_seen, 1);
            prev_en  = ENABLE;
            prev_dir = UP_DOWN;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int t;

        // Reset state.
        RSTn = 1'b0;
        wait_cyc(3);
        check("reset_enable", ENABLE, 0);
        check("reset_up_down", UP_DOWN, 1);
        RSTn = 1'b1;
        wait_cyc(5);

        // Single press held 8: release reaches the FSM on the same edge the
        // repeat delay expires, so only the first pulse appears.
        t = cyc;
        BTN_UP = 1'b1;
        push(t + 7, UP);
        wait_cyc(8);
        BTN_UP = 1'b0;
        wait_cyc(15);

        // Held one cycle longer: the first repeat at +15 now fires.
        t = cyc;
        BTN_UP = 1'b1;
        push(t + 7, UP);
        push(t + 15, UP);
        wait_cyc(9);
        BTN_UP = 1'b0;
        wait_cyc(15);

        // Bounce on DOWN: toggles every 2 cycles, last toggle (high) at t+12.
        t = cyc;
        for (int i = 0; i < 6; i++) begin
            BTN_DOWN = (i % 2 == 0);
            wait_cyc(2);
        end
        BTN_DOWN = 1'b1;
        push(t + 19, DOWN);
        wait_cyc(7);
        BTN_DOWN = 1'b0;
        wait_cyc(15);

        // Auto-repeat: UP held 30 cycles; deb falls at t+36, FSM sees it at t+37.
        t = cyc;
        BTN_UP = 1'b1;
        push(t + 7, UP);
        for (int k = 0; k < 8; k++) push(t + 15 + RP * k, UP);
        wait_cyc(30);
        BTN_UP = 1'b0;
        wait_cyc(15);

        // Glitch: 3 cycles high is one sample short of acceptance.
        BTN_UP = 1'b1;
        wait_cyc(3);
        BTN_UP = 1'b0;
        wait_cyc(15);

        // Conflict: DOWN's debounced rise lands on the delay-expiry edge and
        // forces LOCK; releasing DOWN alone keeps LOCK.
        t = cyc;
        BTN_UP = 1'b1;
        push(t + 7, UP);
        wait_cyc(8);
        BTN_DOWN = 1'b1;
        wait_cyc(12);
        BTN_DOWN = 1'b0;
        wait_cyc(14);
        BTN_UP = 1'b0;
        wait_cyc(16);
        BTN_DOWN = 1'b1;
        push(t + 57, DOWN);
        wait_cyc(6);
        BTN_DOWN = 1'b0;
        wait_cyc(15);

        // Reset while DOWN repeats; DOWN stays held through and after reset.
        t = cyc;
        BTN_DOWN = 1'b1;
        push(t + 7, DOWN);
        push(t + 15, DOWN);
        push(t + 18, DOWN);
        push(t + 21, DOWN);
        wait_cyc(22);
        RSTn = 1'b0;
        wait_cyc(1);
        check("mid_reset_enable", ENABLE, 0);
        check("mid_reset_up_down", UP_DOWN, 1);
        wait_cyc(1);
        RSTn = 1'b1;
        push(t + 31, DOWN);
        wait_cyc(8);
        BTN_DOWN = 1'b0;
        wait_cyc(15);

        check("all_expected_pulses_seen", sb.size(), 0);
        done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
